// File: rtl/opc6_io_timer_irq.sv
// OPC6 I/O responder: interval timer, software interrupt latch
// and active-low interrupt request lines.
module opc6_io_timer_irq #(
  parameter logic [15:0] BASE           = 16'hFF00,
  parameter logic [7:0]  RESET_PRESCALE = 8'h00
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        clken,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  input  logic        rnw,
  input  logic        vio,
  output logic [15:0] rdata,
  output logic [1:0]  int_b
);

  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        ie0_q, ie0_d;
  logic        ie1_q, ie1_d;
  logic [7:0]  pre_q, pre_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  psc_q, psc_d;
  logic        tif_q, tif_d;
  logic        swif_q, swif_d;

  logic        sel;
  logic [2:0]  off;
  logic        wr;
  logic        tick;
  logic        expire;

  assign sel    = vio && (address[15:3] == BASE[15:3]);
  assign off    = address[2:0];
  assign wr     = sel && !rnw;
  assign tick   = en_q && (psc_q == 8'd0);
  assign expire = tick && (count_q == 16'd0);

  // Next-state: timer progress first, then bus writes override.
  always_comb begin
    en_d     = en_q;
    auto_d   = auto_q;
    ie0_d    = ie0_q;
    ie1_d    = ie1_q;
    pre_d    = pre_q;
    reload_d = reload_q;
    count_d  = count_q;
    psc_d    = psc_q;
    tif_d    = tif_q;
    swif_d   = swif_q;

    if (en_q) begin
      psc_d = tick ? pre_q : psc_q - 8'd1;
    end

    if (expire) begin
      if (auto_q) count_d = reload_q;
      else        en_d    = 1'b0;
    end else if (tick) begin
      count_d = count_q - 16'd1;
    end

    if (wr) begin
      unique case (off)
        3'd0: begin
          en_d   = wdata[0];
          auto_d = wdata[1];
          ie0_d  = wdata[2];
          ie1_d  = wdata[3];
          pre_d  = wdata[15:8];
          if (!en_q && wdata[0]) psc_d = wdata[15:8];
        end
        3'd1: reload_d = wdata;
        3'd2: count_d  = wdata;
        3'd3: begin
          if (wdata[0]) tif_d  = 1'b0;
          if (wdata[1]) swif_d = 1'b0;
        end
        3'd4: swif_d = 1'b1;
        default: ;
      endcase
    end

    // A timer expiry beats a simultaneous clear of TIF.
    if (expire) tif_d = 1'b1;
  end

  // State registers advance only on clock-enabled edges.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ie0_q    <= 1'b0;
      ie1_q    <= 1'b0;
      pre_q    <= RESET_PRESCALE;
      reload_q <= 16'h0000;
      count_q  <= 16'h0000;
      psc_q    <= 8'h00;
      tif_q    <= 1'b0;
      swif_q   <= 1'b0;
    end else if (clken) begin
      en_q     <= en_d;
      auto_q   <= auto_d;
      ie0_q    <= ie0_d;
      ie1_q    <= ie1_d;
      pre_q    <= pre_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      psc_q    <= psc_d;
      tif_q    <= tif_d;
      swif_q   <= swif_d;
    end
  end

  // Zero-latency read mux; idle cycles return 0 for OR-ing.
  always_comb begin
    rdata = 16'h0000;
    if (sel && rnw) begin
      unique case (off)
        3'd0: rdata = {pre_q, 4'h0, ie1_q, ie0_q,
                       auto_q, en_q};
        3'd1: rdata = reload_q;
        3'd2: rdata = count_q;
        3'd3: rdata = {14'h0000, swif_q, tif_q};
        default: rdata = 16'h0000;
      endcase
    end
  end

  assign int_b[0] = !(tif_q && ie0_q);
  assign int_b[1] = !(swif_q && ie1_q);

endmodule
